fir_out_decim: RTL



---
 rtl/fir_out_pkg.sv | 29 ++
 rtl/fir_out_fifo.sv | 81 ++++++++
 rtl/fir_out_decim.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/fir_out_pkg.sv
// Shared types and constants for the FIR output decimation stage.
// The optional boxcar-average mode is enabled by the FIR_OUT_DECIM_AVG_EN macro.
package fir_out_pkg;

  // Warm-up discards samples; run keeps one sample per decimation frame.
  typedef enum logic {
    WARM = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int WIDTH_DEFAULT = 16;
  localparam int DROP_CNT_W    = 8;

  // Smallest r such that 2**r >= value; used to size counters and pointers.
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = 1;
    for (int i = 0; i < 32; i++) begin
      if (v < value) begin
        v = v << 1;
        r = r + 1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/fir_out_fifo.sv
// Synchronous DEPTH-entry FIFO with a registered head (m_data/m_valid).
// A push and a pop may occur on the same edge, including when full.
module fir_out_fifo
  import fir_out_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             m_valid,
  output logic [WIDTH-1:0] m_data
);

  localparam int AW = (clog2(DEPTH) > 0) ? clog2(DEPTH) : 1;
  localparam int CW = clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [CW-1:0]    count;
  logic             do_pop;
  logic             do_push;
  logic [CW-1:0]    count_after_pop;
  logic [CW-1:0]    count_next;
  logic [AW-1:0]    rd_next;

  // Work out which transfers happen this edge and where the head moves to.
  always_comb begin
    full            = (count == CW'(DEPTH));
    do_pop          = m_valid && pop;
    do_push         = push && (!full || do_pop);
    count_after_pop = count - CW'(do_pop);
    count_next      = count_after_pop + CW'(do_push);
    rd_next         = rd_ptr + AW'(do_pop);
  end

  // Storage array has no reset; only slots that are later counted as valid are read.
  always_ff @(posedge clk) begin
    if (!rst && !flush && do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers, occupancy and the registered head; the head is loaded from the
  // incoming sample when it would land in an otherwise empty FIFO.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count   <= '0;
      m_valid <= 1'b0;
      m_data  <= '0;
    end else if (flush) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count   <= '0;
      m_valid <= 1'b0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      rd_ptr  <= rd_next;
      count   <= count_next;
      m_valid <= (count_next != '0);
      if (count_after_pop == '0) begin
        if (do_push) begin
          m_data <= push_data;
        end
      end else begin
        m_data <= mem[rd_next];
      end
    end
  end

endmodule

// File: rtl/fir_out_decim.sv
// Output stage after the 9-tap FIR: drops the warm-up transient, decimates by
// DECIM, buffers kept samples in a small FIFO and counts overflow drops.
// Define FIR_OUT_DECIM_AVG_EN to output a boxcar average of each frame instead
// of picking the first sample of the frame.
module fir_out_decim
  import fir_out_pkg::*;
#(
  parameter int WIDTH  = WIDTH_DEFAULT,
  parameter int DECIM  = 4,
  parameter int WARMUP = 9,
  parameter int DEPTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_en,
  input  logic [WIDTH-1:0]      y_in,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [WIDTH-1:0]      m_data,
  output logic                  warm_done,
  output logic                  ovf_sticky,
  output logic [DROP_CNT_W-1:0] drop_cnt
);

  localparam int LOG2D = clog2(DECIM);
  localparam int PW    = (LOG2D > 0) ? LOG2D : 1;
  localparam int WW    = (clog2(WARMUP + 1) > 0) ? clog2(WARMUP + 1) : 1;

  localparam logic [PW-1:0] PHASE_LAST = PW'(DECIM - 1);
  localparam logic [WW-1:0] WARM_LAST  = WW'(WARMUP - 1);

  state_t           state;
  logic [PW-1:0]    phase;
  logic [WW-1:0]    warm_cnt;
  logic             run_en;
  logic             push;
  logic [WIDTH-1:0] push_data;
  logic             fifo_full;
  logic             drop;

  // A sample counts toward the frame only in RUN and never during a flush.
  always_comb begin
    run_en = (state == RUN) && in_en && !flush;
  end

`ifdef FIR_OUT_DECIM_AVG_EN
  localparam int ACC_W = WIDTH + LOG2D;

  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] y_ext;
  logic signed [ACC_W-1:0] sum;
  logic signed [ACC_W-1:0] avg;

  // Frame sum including the current sample, floored average by arithmetic shift.
  always_comb begin
    y_ext     = ACC_W'($signed(y_in));
    sum       = acc + y_ext;
    avg       = sum >>> LOG2D;
    push_data = avg[WIDTH-1:0];
    push      = run_en && (phase == PHASE_LAST);
  end

  // Accumulate the frame, restarting after the last sample of each frame.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      acc <= '0;
    end else if (run_en) begin
      if (phase == PHASE_LAST) begin
        acc <= '0;
      end else begin
        acc <= sum;
      end
    end
  end
`else
  // Keep the first sample of each frame unchanged.
  always_comb begin
    push_data = y_in;
    push      = run_en && (phase == '0);
  end
`endif

  // Warm-up / run sequencing with the phase counter and registered warm_done.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      state     <= WARM;
      warm_cnt  <= '0;
      phase     <= '0;
      warm_done <= 1'b0;
    end else begin
      case (state)
        WARM: begin
          if (WARMUP == 0) begin
            state     <= RUN;
            warm_done <= 1'b1;
          end else if (in_en) begin
            if (warm_cnt == WARM_LAST) begin
              state     <= RUN;
              warm_cnt  <= '0;
              warm_done <= 1'b1;
            end else begin
              warm_cnt <= warm_cnt + WW'(1);
            end
          end
        end
        RUN: begin
          if (in_en) begin
            if (phase == PHASE_LAST) begin
              phase <= '0;
            end else begin
              phase <= phase + PW'(1);
            end
          end
        end
        default: begin
          state <= WARM;
        end
      endcase
    end
  end

  // A kept sample is lost only when the FIFO is full and nothing leaves this edge.
  always_comb begin
    drop = push && fifo_full && !(m_valid && m_ready);
  end

  // Overflow flag and saturating drop counter survive flush.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_sticky <= 1'b0;
      drop_cnt   <= '0;
    end else if (drop) begin
      ovf_sticky <= 1'b1;
      if (drop_cnt != '1) begin
        drop_cnt <= drop_cnt + DROP_CNT_W'(1);
      end
    end
  end

  fir_out_fifo #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .push     (push),
    .push_data(push_data),
    .pop      (m_ready),
    .full     (fifo_full),
    .m_valid  (m_valid),
    .m_data   (m_data)
  );

endmodule
